mem_port_arbiter: RTL

Shares the single synchronous 8-bit memory between three requesters: instruction fetch (port F), load/store data (port D) and a board-level debug/loader (port G).
- Sits between the control FSM/datapath address sources and the memory macro.
- Replaces the dedicated PC and data address paths with one arbitrated port.
- Provides round-robin fairness between F and D, absolute priority plus bus lock for G, read-response routing, and a saturating conflict counter for the HEX display.

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one synchronous memory port between fetch (F), load/store (D) and debug (G).
// G has absolute priority and can lock the bus; F and D share it round-robin.
module mem_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  input  logic          g_req,
  input  logic          g_we,
  input  logic [AW-1:0] g_addr,
  input  logic [DW-1:0] g_wdata,
  input  logic          g_lock,
  output logic          g_gnt,
  output logic          g_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  output logic          mem_rden,
  input  logic [DW-1:0] mem_q,
  output logic [CW-1:0] conflict_cnt
);

  localparam logic [1:0] ID_F = 2'd0;
  localparam logic [1:0] ID_D = 2'd1;
  localparam logic [1:0] ID_G = 2'd2;
  localparam logic       RR_F = 1'b0;
  localparam logic       RR_D = 1'b1;

  logic          rr_last;
  logic          locked;
  logic          rsp_pending;
  logic [1:0]    rsp_id;
  logic [DW-1:0] rdata_q;
  logic          win_we;
  logic [1:0]    win_id;
  logic          any_gnt;
  logic          any_loser;

  // Grants are forced low while reset is asserted so nothing reaches the memory.
  assign g_gnt = ~reset & g_req;
  assign f_gnt = ~reset & ~locked & ~g_req & f_req & (~d_req | (rr_last == RR_D));
  assign d_gnt = ~reset & ~locked & ~g_req & d_req & (~f_req | (rr_last == RR_F));
  assign any_gnt = f_gnt | d_gnt | g_gnt;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    win_we    = 1'b0;
    win_id    = ID_F;
    if (g_gnt) begin
      mem_addr  = g_addr;
      mem_wdata = g_wdata;
      win_we    = g_we;
      win_id    = ID_G;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      win_we    = d_we;
      win_id    = ID_D;
    end else if (f_gnt) begin
      mem_addr  = f_addr;
      win_id    = ID_F;
    end
  end

  assign mem_wren  = any_gnt & win_we;
  assign mem_rden  = any_gnt & ~win_we;
  assign any_loser = (f_req & ~f_gnt) | (d_req & ~d_gnt) | (g_req & ~g_gnt);

  // The memory returns data the cycle after mem_rden, so the response is steered then.
  assign f_rvalid = rsp_pending & (rsp_id == ID_F);
  assign d_rvalid = rsp_pending & (rsp_id == ID_D);
  assign g_rvalid = rsp_pending & (rsp_id == ID_G);
  assign rdata    = rsp_pending ? mem_q : rdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_last      <= RR_D;
      locked       <= 1'b0;
      rsp_pending  <= 1'b0;
      rsp_id       <= ID_F;
      rdata_q      <= '0;
      conflict_cnt <= '0;
    end else begin
      if (f_gnt) begin
        rr_last <= RR_F;
      end else if (d_gnt) begin
        rr_last <= RR_D;
      end
      // Lock is taken only by a granted G access and drops as soon as g_lock falls.
      locked      <= g_lock & (locked | g_gnt);
      rsp_pending <= mem_rden;
      if (mem_rden) begin
        rsp_id <= win_id;
      end
      if (rsp_pending) begin
        rdata_q <= mem_q;
      end
      if (any_loser && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + CW'(1);
      end
    end
  end

endmodule
